// File: rtl/uart_rx_cfg_if.sv
// uart_rx_cfg bus: serial line in, received word and status out.
// master = receiver side, slave = line driver / word consumer.
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
) ();
  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 busy;

  modport master (
    input  rx,
    output rx_data,
    output rx_valid,
    output parity_err,
    output frame_err,
    output busy
  );

  modport slave (
    output rx,
    input  rx_data,
    input  rx_valid,
    input  parity_err,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 3-sample majority vote at bit centre,
// optional parity, 1/2 stop bits, false-start rejection.
module uart_rx_cfg #(
  parameter int CLK_DIV   = 5208,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_cfg_if.master bus
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int H  = CLK_DIV / 2;

  localparam logic [CW-1:0] C_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] C_S0   = CW'(H - 1);
  localparam logic [CW-1:0] C_S1   = CW'(H);
  localparam logic [CW-1:0] C_RES  = CW'(H + 1);
  localparam logic [3:0]    B_LAST = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t state_q, state_d;

  logic rx_m_q, rx_s_q, hist_q;

  logic [CW-1:0] bps_cnt_q, bps_cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic          smp0_q, smp0_d;
  logic          smp1_q, smp1_d;

  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 perr_pend_q, perr_pend_d;
  logic                 ferr_pend_q, ferr_pend_d;

  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;

  logic fall, at_last, at_res, vote, last_stop;
  logic strobe, busy;

  assign fall      = hist_q & ~rx_s_q;
  assign at_last   = (bps_cnt_q == C_LAST);
  assign at_res    = (bps_cnt_q == C_RES);
  assign vote      = (smp0_q & smp1_q) |
                     (smp0_q & rx_s_q) |
                     (smp1_q & rx_s_q);
  assign last_stop = (STOP_BITS == 1) || (bit_cnt_q == 4'd1);

  // Synchroniser and edge-history flops; idle-high on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
      hist_q <= 1'b1;
    end else begin
      rx_m_q <= bus.rx;
      rx_s_q <= rx_m_q;
      hist_q <= rx_s_q;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: leave STOP at last-stop resolve, half a bit early
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (fall) state_d = S_START;
      end
      S_START: begin
        if (at_res && vote) state_d = S_IDLE;
        else if (at_last) state_d = S_DATA;
      end
      S_DATA: begin
        if (at_last && bit_cnt_q == B_LAST)
          state_d = (PARITY != 0) ? S_PAR : S_STOP;
      end
      S_PAR: begin
        if (at_last) state_d = S_STOP;
      end
      S_STOP: begin
        if (at_res && last_stop) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: strobe and result words visible in the resolve cycle
  always_comb begin
    strobe    = (state_q == S_STOP) && at_res && last_stop;
    busy      = (state_q != S_IDLE);
    rx_data_d = rx_data_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    if (strobe) begin
      rx_data_d = shreg_q;
      perr_d    = perr_pend_q;
      ferr_d    = ferr_pend_q | ~vote;
    end
  end

  // Datapath next-state: bit timing, samples, shift and pending flags
  always_comb begin
    bps_cnt_d   = '0;
    bit_cnt_d   = bit_cnt_q;
    smp0_d      = smp0_q;
    smp1_d      = smp1_q;
    shreg_d     = shreg_q;
    perr_pend_d = perr_pend_q;
    ferr_pend_d = ferr_pend_q;

    if (state_q != S_IDLE && state_d != S_IDLE && !at_last)
      bps_cnt_d = bps_cnt_q + 1'b1;

    if (state_d != state_q)
      bit_cnt_d = '0;
    else if (at_last && (state_q == S_DATA || state_q == S_STOP))
      bit_cnt_d = bit_cnt_q + 1'b1;

    if (bps_cnt_q == C_S0) smp0_d = rx_s_q;
    if (bps_cnt_q == C_S1) smp1_d = rx_s_q;

    if (state_q == S_DATA && at_res)
      shreg_d = {vote, shreg_q[DATA_BITS-1:1]};

    if (state_q == S_IDLE) begin
      perr_pend_d = 1'b0;
      ferr_pend_d = 1'b0;
    end

    if (state_q == S_PAR && at_res)
      perr_pend_d = (PARITY == 2) ^ (^shreg_q) ^ vote;

    if (state_q == S_STOP && at_res && !vote)
      ferr_pend_d = 1'b1;
  end

  // Datapath and held-output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bps_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      smp0_q      <= 1'b0;
      smp1_q      <= 1'b0;
      shreg_q     <= '0;
      perr_pend_q <= 1'b0;
      ferr_pend_q <= 1'b0;
      rx_data_q   <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      bps_cnt_q   <= bps_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      smp0_q      <= smp0_d;
      smp1_q      <= smp1_d;
      shreg_q     <= shreg_d;
      perr_pend_q <= perr_pend_d;
      ferr_pend_q <= ferr_pend_d;
      rx_data_q   <= rx_data_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
    end
  end

  assign bus.rx_data    = rx_data_d;
  assign bus.rx_valid   = strobe;
  assign bus.parity_err = perr_d;
  assign bus.frame_err  = ferr_d;
  assign bus.busy       = busy;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: 8N1, 8E1 and 7O2 instances,
// CLK_DIV = 16, shared clock and reset.
module tb_uart_rx_cfg;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx_a = 1'b1;
  logic rx_b = 1'b1;
  logic rx_c = 1'b1;
  int   cyc = 0;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  uart_rx_cfg_if #(.DATA_BITS(8)) ifa ();
  uart_rx_cfg_if #(.DATA_BITS(8)) ifb ();
  uart_rx_cfg_if #(.DATA_BITS(7)) ifc ();

  assign ifa.rx = rx_a;
  assign ifb.rx = rx_b;
  assign ifc.rx = rx_c;

  uart_rx_cfg #(
    .CLK_DIV(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) u_a (.clk(clk), .rst(rst), .bus(ifa));

  uart_rx_cfg #(
    .CLK_DIV(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)
  ) u_b (.clk(clk), .rst(rst), .bus(ifb));

  uart_rx_cfg #(
    .CLK_DIV(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)
  ) u_c (.clk(clk), .rst(rst), .bus(ifc));

  int         na = 0, nb = 0, nc = 0;
  int         ta = 0;
  logic [7:0] da;
  logic       pa, fa;
  logic [7:0] db;
  logic       pb, fb;
  int         tc [2];
  logic [6:0] dc [2];
  logic       pc [2];
  logic       fc [2];

  // strobe capture, sampled mid-cycle
  always @(negedge clk) begin
    if (ifa.rx_valid) begin
      na++;
      ta = cyc;
      da = ifa.rx_data;
      pa = ifa.parity_err;
      fa = ifa.frame_err;
    end
    if (ifb.rx_valid) begin
      nb++;
      db = ifb.rx_data;
      pb = ifb.parity_err;
      fb = ifb.frame_err;
    end
    if (ifc.rx_valid) begin
      if (nc < 2) begin
        tc[nc] = cyc;
        dc[nc] = ifc.rx_data;
        pc[nc] = ifc.parity_err;
        fc[nc] = ifc.frame_err;
      end
      nc++;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_line(input int sel, input logic v);
    case (sel)
      0: rx_a = v;
      1: rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  // one frame, 16 cycles per bit; optional single-cycle inversion
  // at cycle go of frame bit gb (frame bit 0 = start bit)
  task automatic send_frame(input int sel,
                            input logic [8:0] data,
                            input int nd,
                            input int has_par,
                            input logic pbit,
                            input int ns,
                            input logic sval,
                            input int gb,
                            input int go);
    int   nbits;
    logic b;
    nbits = 1 + nd + has_par + ns;
    for (int i = 0; i < nbits; i++) begin
      if (i == 0) b = 1'b0;
      else if (i <= nd) b = data[i-1];
      else if (has_par != 0 && i == nd + 1) b = pbit;
      else b = sval;
      for (int j = 0; j < 16; j++) begin
        set_line(sel, (i == gb && j == go) ? ~b : b);
        @(negedge clk);
      end
    end
  endtask

  int t0;
  int n0;

  initial begin
    // reset state
    repeat (4) @(negedge clk);
    chk("rst_a_data", 32'(ifa.rx_data), 0);
    chk("rst_a_valid", 32'(ifa.rx_valid), 0);
    chk("rst_a_busy", 32'(ifa.busy), 0);
    chk("rst_a_flags", {30'd0, ifa.parity_err, ifa.frame_err}, 0);
    chk("rst_c_data", 32'(ifc.rx_data), 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // 8N1 0xA5, strobe E+154 = drive+156
    t0 = cyc;
    send_frame(0, 9'h0A5, 8, 0, 1'b0, 1, 1'b1, -1, -1);
    repeat (4) @(negedge clk);
    chk("a5_count", 32'(na), 1);
    chk("a5_latency", 32'(ta - t0), 156);
    chk("a5_data", 32'(da), 32'h A5);
    chk("a5_flags", {30'd0, pa, fa}, 0);
    chk("a5_busy_after", 32'(ifa.busy), 0);

    // 8E1 0x03 with parity bit 1 (error), then 0 (clean)
    send_frame(1, 9'h003, 8, 1, 1'b1, 1, 1'b1, -1, -1);
    repeat (4) @(negedge clk);
    chk("e_bad_count", 32'(nb), 1);
    chk("e_bad_data", 32'(db), 32'h03);
    chk("e_bad_perr", 32'(pb), 1);
    send_frame(1, 9'h003, 8, 1, 1'b0, 1, 1'b1, -1, -1);
    repeat (4) @(negedge clk);
    chk("e_ok_count", 32'(nb), 2);
    chk("e_ok_perr", 32'(pb), 0);
    chk("e_ok_ferr", 32'(fb), 0);

    // 7O2 back-to-back 0x41 (par 1), 0x7F (par 0)
    t0 = cyc;
    send_frame(2, 9'h041, 7, 1, 1'b1, 2, 1'b1, -1, -1);
    send_frame(2, 9'h07F, 7, 1, 1'b0, 2, 1'b1, -1, -1);
    repeat (4) @(negedge clk);
    chk("o2_count", 32'(nc), 2);
    chk("o2_latency", 32'(tc[0] - t0), 172);
    chk("o2_gap", 32'(tc[1] - tc[0]), 176);
    chk("o2_data0", 32'(dc[0]), 32'h41);
    chk("o2_data1", 32'(dc[1]), 32'h7F);
    chk("o2_flags", {28'd0, pc[0], fc[0], pc[1], fc[1]}, 0);

    // 8N1 0x5A with low stop bit, then break held 40 cycles
    n0 = na;
    send_frame(0, 9'h05A, 8, 0, 1'b0, 1, 1'b0, -1, -1);
    chk("fe_count", 32'(na - n0), 1);
    chk("fe_data", 32'(da), 32'h5A);
    chk("fe_ferr", 32'(fa), 1);
    repeat (40) @(negedge clk);
    chk("brk_count", 32'(na - n0), 1);
    chk("brk_busy", 32'(ifa.busy), 0);
    set_line(0, 1'b1);
    repeat (20) @(negedge clk);

    // false start: 4 low cycles
    n0 = na;
    t0 = cyc;
    set_line(0, 1'b0);
    repeat (4) @(negedge clk);
    set_line(0, 1'b1);
    @(negedge clk);
    chk("fs_busy_hi", 32'(ifa.busy), 1);
    while (cyc < t0 + 12) @(negedge clk);
    chk("fs_busy_res", 32'(ifa.busy), 1);
    @(negedge clk);
    chk("fs_busy_lo", 32'(ifa.busy), 0);
    repeat (30) @(negedge clk);
    chk("fs_count", 32'(na - n0), 0);
    chk("fs_hold_data", 32'(ifa.rx_data), 32'h5A);
    chk("fs_hold_ferr", 32'(ifa.frame_err), 1);

    // 0xFF with 1-cycle low glitch at bps_cnt = 8 of data bit 3
    n0 = na;
    send_frame(0, 9'h0FF, 8, 0, 1'b0, 1, 1'b1, 4, 9);
    repeat (4) @(negedge clk);
    chk("gl_count", 32'(na - n0), 1);
    chk("gl_data", 32'(da), 32'h FF);
    chk("gl_ferr", 32'(fa), 0);

    // reset mid data bit 4 of an all-ones frame
    n0 = na;
    set_line(0, 1'b0);
    repeat (16) @(negedge clk);
    set_line(0, 1'b1);
    repeat (72) @(negedge clk);
    chk("mr_busy_pre", 32'(ifa.busy), 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("mr_data", 32'(ifa.rx_data), 0);
    chk("mr_busy", 32'(ifa.busy), 0);
    chk("mr_ferr", 32'(ifa.frame_err), 0);
    rst = 1'b1;
    repeat (120) @(negedge clk);
    chk("mr_count", 32'(na - n0), 0);
    chk("mr_data_after", 32'(ifa.rx_data), 0);

    // clean frame after reset
    send_frame(0, 9'h03C, 8, 0, 1'b0, 1, 1'b1, -1, -1);
    repeat (4) @(negedge clk);
    chk("post_count", 32'(na - n0), 1);
    chk("post_data", 32'(da), 32'h3C);
    chk("post_flags", {30'd0, pa, fa}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver, next generation of the stage-1 receive path. It adds configurable data width, optional even/odd parity, 1 or 2 stop bits, 3-sample majority voting at bit centre, and false-start rejection. It reports per-frame parity and framing errors. It delivers each received word with a single-cycle valid strobe to downstream logic such as a command parser or FIFO.

Parameters:
CLK_DIV, 5208, clk cycles per bit (baud period); legal range 8..2^20
DATA_BITS, 8, data bits per frame; legal range 5..9
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, number of stop bits; 1 or 2

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
rx  input  1  serial line, idle high, asynchronous to clk
rx_data  output  DATA_BITS  last received word, LSB = first data bit on the line
rx_valid  output  1  one-cycle strobe: rx_data and the error flags are updated this cycle
parity_err  output  1  parity mismatch on the last frame; always 0 when PARITY = 0
frame_err  output  1  a stop bit was sampled low on the last frame
busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (rst low, async): rx_data = 0, rx_valid = 0, parity_err = 0, frame_err = 0, busy = 0, FSM = IDLE, synchroniser flops = 1, all counters = 0.
- Input path: 2-flop synchroniser (rx_s) followed by one history flop. A falling edge is history = 1 and rx_s = 0.
- Counters:
  - bps_cnt counts 0..CLK_DIV-1 and wraps. It is cleared in the cycle after an edge is detected in IDLE.
  - H = CLK_DIV/2, integer division.
  - Samples are taken at bps_cnt = H-1, H, H+1. The bit value is the majority of the 3 samples and is resolved at bps_cnt = H+1.
  - bit_cnt indexes the current bit within the DATA state.
- FSM states:
  - IDLE: on a falling edge, go to START; bps_cnt = 0.
  - START: at resolve, if the voted bit is 1 (false start), return to IDLE with no strobe and no flag change. Otherwise continue. At bps_cnt = CLK_DIV-1, go to DATA with bit_cnt = 0.
  - DATA: at resolve, shift the voted bit into the shift register, LSB first. At bps_cnt = CLK_DIV-1: if bit_cnt = DATA_BITS-1, go to PAR (PARITY != 0) or STOP; else increment bit_cnt.
  - PAR: at resolve, compute the error. Even: error if XOR(data, parity bit) = 1. Odd: error if it = 0. At bps_cnt = CLK_DIV-1, go to STOP.
  - STOP: sample each stop bit. Any voted 0 sets the pending frame error.
    - At resolve of the last stop bit: rx_valid = 1 for exactly one cycle; rx_data, parity_err and frame_err load together; FSM goes to IDLE in the same cycle.
    - The return to IDLE is half a bit early, so a following start edge is never missed.
    - With STOP_BITS = 2, the first stop bit runs a full period before the second.
- Output holding: outputs hold between strobes. The flags describe only the most recent frame.
- Frame error / break: rx_data still loads, and frame_err = 1.
  - If the line stays low (break), IDLE sees no falling edge, so no new frame starts until the line has gone high and then low again.
- Reset mid-frame: the frame is aborted immediately and no strobe is issued. The first frame after reset requires a fresh falling edge.
- Glitch tolerance: a single-cycle glitch within the sample window is outvoted. A low pulse that is not low by majority at the START resolve point is rejected.
- Latency: let E be the first cycle rx_s is low. rx_valid asserts at cycle E + 1 + (1 + DATA_BITS + P + STOP_BITS - 1)·CLK_DIV + H + 1, where P = 1 if PARITY != 0, else 0.
- Widths: bps_cnt is $clog2(CLK_DIV) bits; bit_cnt is 4 bits. There is no arithmetic overflow: every compare is exact equality.

Test Plan:
- CLK_DIV=16, 8N1, send 0xA5 -> one rx_valid; rx_data = 0xA5; parity_err = frame_err = 0; strobe at E+1+9·16+9 = E+154.
- CLK_DIV=16, PARITY=1, send 0x03 with parity bit 1 -> rx_valid, rx_data = 0x03, parity_err = 1. Resend with parity bit 0 -> parity_err returns to 0.
- CLK_DIV=16, rx low for 4 cycles then high -> no rx_valid; busy returns to 0 after START resolve (bps_cnt = 9); flags unchanged.
- CLK_DIV=16, send 0x5A with stop bit driven 0 -> rx_valid, rx_data = 0x5A, frame_err = 1. Then hold the line low for 40 cycles -> no further strobe.
- CLK_DIV=16, 0xFF with a 1-cycle low glitch at bps_cnt = H in data bit 3 -> rx_data = 0xFF. Separately, assert rst mid-bit-4 -> all outputs 0, no strobe; the next frame 0x3C is received correctly.
- CLK_DIV=16, DATA_BITS=7, STOP_BITS=2, PARITY=2, back-to-back 0x41, 0x7F with no idle gap -> two strobes 176 cycles apart; both words correct and all flags 0.
